// File: rtl/fetch_seq.sv
// Fetch stage of the sequential Y86 core: holds the PC, reads an instruction one byte
// at a time from byte-wide instruction memory and splits it into icode/ifun/rA/rB/valC/valP.
module fetch_seq #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          IMEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] new_pc,
    input  logic        pc_load,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [31:0] valC,
    output logic [31:0] valP,
    output logic        instr_valid,
    output logic [2:0]  stat,
    output logic [1:0]  dbgState
);

    // Handshake: a byte transfers on every rising edge where mem_req && mem_ack are both high;
    // mem_addr is held stable from the first cycle of mem_req until that transfer happens.

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        DONE = 2'd1,
        STOP = 2'd2
    } fetchState_t;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_SIZE);
    localparam logic [2:0]  STAT_AOK   = 3'd1;
    localparam logic [2:0]  STAT_HLT   = 3'd2;
    localparam logic [2:0]  STAT_ADR   = 3'd3;
    localparam logic [2:0]  STAT_INS   = 3'd4;

    fetchState_t state;
    fetchState_t stateNext;
    logic [2:0]  byteIdx;
    logic [31:0] byteAddr;
    logic        adrFault;
    logic        take;
    logic        badCode;
    logic [2:0]  curLen;
    logic        lastByte;
    logic        regByte;
    logic        constByte;
    logic [1:0]  constSlot;

    function automatic logic [2:0] lenOf(input logic [3:0] code);
        logic [2:0] len;
        len = 3'd1;
        case (code)
            4'h0, 4'h1, 4'h9:       len = 3'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 3'd2;
            4'h3, 4'h4, 4'h5:       len = 3'd6;
            4'h7, 4'h8:             len = 3'd5;
            default:                len = 3'd1;
        endcase
        return len;
    endfunction

    assign byteAddr = pc + {29'd0, byteIdx};
    assign adrFault = (byteAddr >= IMEM_LIMIT);
    assign take     = mem_req && mem_ack;

    // Byte 0 is still on the bus, so its length comes from mem_rdata rather than icode.
    assign badCode  = (byteIdx == 3'd0) && (mem_rdata[7:4] > 4'hB);
    assign curLen   = (byteIdx == 3'd0) ? lenOf(mem_rdata[7:4]) : lenOf(icode);
    assign lastByte = (byteIdx == (curLen - 3'd1));

    assign regByte   = (byteIdx == 3'd1) && ((curLen == 3'd2) || (curLen == 3'd6));
    assign constByte = ((curLen == 3'd6) && (byteIdx >= 3'd2)) ||
                       ((curLen == 3'd5) && (byteIdx >= 3'd1));
    assign constSlot = (curLen == 3'd6) ? 2'(byteIdx - 3'd2) : 2'(byteIdx - 3'd1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            REQ: begin
                if (adrFault) begin
                    stateNext = STOP;
                end else if (take) begin
                    if (badCode) begin
                        stateNext = STOP;
                    end else if (lastByte) begin
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                if (icode == 4'h0) begin
                    stateNext = STOP;
                end else if (pc_load) begin
                    stateNext = REQ;
                end
            end
            STOP:    stateNext = STOP;
            default: stateNext = STOP;
        endcase
    end

    // Output logic; the request drops with rst_n so an in-flight fetch aborts immediately.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = byteAddr;
        dbgState = state;
        if (state == REQ && !adrFault && rst_n) begin
            mem_req = 1'b1;
        end
    end

    // Datapath: PC, byte counter, decoded fields and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            byteIdx     <= 3'd0;
            icode       <= 4'h0;
            ifun        <= 4'h0;
            rA          <= 4'hF;
            rB          <= 4'hF;
            valC        <= 32'h0;
            valP        <= RESET_PC;
            instr_valid <= 1'b0;
            stat        <= STAT_AOK;
        end else begin
            case (state)
                REQ: begin
                    if (adrFault) begin
                        stat <= STAT_ADR;
                    end else if (take) begin
                        byteIdx <= byteIdx + 3'd1;
                        if (byteIdx == 3'd0) begin
                            icode <= mem_rdata[7:4];
                            ifun  <= mem_rdata[3:0];
                        end
                        if (badCode) begin
                            stat        <= STAT_INS;
                            instr_valid <= 1'b1;
                        end else begin
                            if (regByte) begin
                                rA <= mem_rdata[7:4];
                                rB <= mem_rdata[3:0];
                            end
                            if (constByte) begin
                                valC[{constSlot, 3'b000} +: 8] <= mem_rdata;
                            end
                            if (lastByte) begin
                                valP        <= pc + {29'd0, curLen};
                                instr_valid <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (icode == 4'h0) begin
                        stat <= STAT_HLT;
                    end else if (pc_load) begin
                        pc          <= new_pc;
                        byteIdx     <= 3'd0;
                        icode       <= 4'h0;
                        ifun        <= 4'h0;
                        rA          <= 4'hF;
                        rB          <= 4'hF;
                        valC        <= 32'h0;
                        valP        <= new_pc;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
